// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one buffered result per source, one CDB broadcast per cycle.
// Ports: Clock/Reset(async, low)/Flush; Fu_req/tag/data in, Fu_ready out;
//   CDB_valid/Qi_CDB/Qi_CDB_data registered broadcast.
// Build option: CDB_FIXED_PRIORITY_EN selects lowest-index-wins grant (no rr_ptr).
module cdb_arbiter #(
  parameter int N_SRC = 3,
  parameter int TAG_W = 4,
  parameter int DATA_W = 16,
  parameter logic [TAG_W-1:0] TAG_NONE = '0,
  parameter logic [DATA_W-1:0] DATA_NONE = DATA_W'(16'hFFF0)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Flush,
  input  logic [N_SRC-1:0]        Fu_req,
  input  logic [N_SRC*TAG_W-1:0]  Fu_tag,
  input  logic [N_SRC*DATA_W-1:0] Fu_data,
  output logic [N_SRC-1:0]        Fu_ready,
  output logic                    CDB_valid,
  output logic [TAG_W-1:0]        Qi_CDB,
  output logic [DATA_W-1:0]       Qi_CDB_data
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_SRC - 1);

  logic [N_SRC-1:0]  buf_valid;
  logic [TAG_W-1:0]  buf_tag [N_SRC];
  logic [DATA_W-1:0] buf_data [N_SRC];

  logic [N_SRC-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [N_SRC-1:0] take;

`ifndef CDB_FIXED_PRIORITY_EN
  logic [PW-1:0] rr_ptr;
`endif

  // Scan buffers starting at the round-robin pointer (or index 0).
  always_comb begin
    int j;
    gnt = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j = 0;
    for (int k = 0; k < N_SRC; k++) begin
`ifdef CDB_FIXED_PRIORITY_EN
      j = k;
`else
      j = int'(rr_ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
`endif
      if (!gnt_any && buf_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
        gnt[j]  = 1'b1;
      end
    end
  end

  // A granted buffer drains at the same edge, so it can refill.
  assign Fu_ready = ~buf_valid | gnt;

  // Null-tag requests are acknowledged but never stored.
  always_comb begin
    take = '0;
    for (int i = 0; i < N_SRC; i++) begin
      take[i] = Fu_req[i] & Fu_ready[i] &
                (Fu_tag[i*TAG_W +: TAG_W] != TAG_NONE);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      buf_valid   <= '0;
      CDB_valid   <= 1'b0;
      Qi_CDB      <= TAG_NONE;
      Qi_CDB_data <= DATA_NONE;
`ifndef CDB_FIXED_PRIORITY_EN
      rr_ptr      <= '0;
`endif
      for (int i = 0; i < N_SRC; i++) begin
        buf_tag[i]  <= TAG_NONE;
        buf_data[i] <= '0;
      end
    end else if (Flush) begin
      buf_valid   <= '0;
      CDB_valid   <= 1'b0;
      Qi_CDB      <= TAG_NONE;
      Qi_CDB_data <= DATA_NONE;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (take[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= Fu_tag[i*TAG_W +: TAG_W];
          buf_data[i]  <= Fu_data[i*DATA_W +: DATA_W];
        end else if (gnt[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (gnt_any) begin
        CDB_valid   <= 1'b1;
        Qi_CDB      <= buf_tag[gnt_idx];
        Qi_CDB_data <= buf_data[gnt_idx];
`ifndef CDB_FIXED_PRIORITY_EN
        rr_ptr      <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
`endif
      end else begin
        CDB_valid   <= 1'b0;
        Qi_CDB      <= TAG_NONE;
        Qi_CDB_data <= DATA_NONE;
      end
    end
  end

endmodule
